// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings, line idle level and default baud divisor.
// The UART receiver imports the same package so both ends agree on encodings.
package uart_tx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    // 100 MHz system clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_tx_if.sv
// Handshake and line signals between the system-side command logic (master)
// and the UART transmitter (slave).
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_serial;
    logic                  tx_done;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_serial,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_serial,
        output tx_done
    );
endinterface

// File: rtl/piso_shift_reg_uart.sv
// Parallel-in serial-out shift register: loads a word, shifts right on enable,
// filling from the MSB with the idle level so the line defaults high.
module piso_shift_reg_uart
    import uart_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] load_data,
    output logic             serial_out
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == WIDTH - 1) begin : g_msb
                assign q_next[gi] = load     ? load_data[gi] :
                                    shift_en ? UART_IDLE_LEVEL : q_reg[gi];
            end else begin : g_low
                assign q_next[gi] = load     ? load_data[gi] :
                                    shift_en ? q_reg[gi+1] : q_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= {WIDTH{UART_IDLE_LEVEL}};
        end else begin
            q_reg <= q_next;
        end
    end

    assign serial_out = q_reg[0];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word in, start + LSB-first data + stop bits out
// on a registered, idle-high serial line.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_WIDTH   = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  tx
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    logic [1:0]        state_reg;
    logic [BAUD_W-1:0] baud_cnt_reg;
    logic [BIT_W-1:0]  bit_cnt_reg;
    logic              tx_serial_reg;
    logic              tx_ready_reg;
    logic              tx_done_reg;

    logic accept;
    logic bit_end;
    logic sh_shift;
    logic sh_out;

    always_comb begin
        accept   = tx.tx_valid && tx_ready_reg;
        bit_end  = (state_reg != ST_IDLE) && (baud_cnt_reg == BAUD_LAST);
        // The shift register runs one bit ahead of the line: each bit boundary
        // registers the current LSB onto the line and exposes the next one.
        sh_shift = bit_end && ((state_reg == ST_START) || (state_reg == ST_DATA));
    end

    piso_shift_reg_uart #(
        .WIDTH(DATA_WIDTH)
    ) u_shreg (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .shift_en   (sh_shift),
        .load_data  (tx.tx_data),
        .serial_out (sh_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            baud_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            tx_serial_reg <= UART_IDLE_LEVEL;
            tx_ready_reg  <= 1'b1;
            tx_done_reg   <= 1'b0;
        end else begin
            tx_done_reg <= 1'b0;
            if (state_reg == ST_IDLE || bit_end) begin
                baud_cnt_reg <= '0;
            end else begin
                baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
            end

            case (state_reg)
                ST_IDLE: begin
                    bit_cnt_reg   <= '0;
                    tx_serial_reg <= UART_IDLE_LEVEL;
                    if (accept) begin
                        state_reg     <= ST_START;
                        tx_ready_reg  <= 1'b0;
                        tx_serial_reg <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_reg     <= ST_DATA;
                        tx_serial_reg <= sh_out;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt_reg == DATA_LAST) begin
                            state_reg     <= ST_STOP;
                            bit_cnt_reg   <= '0;
                            tx_serial_reg <= UART_IDLE_LEVEL;
                        end else begin
                            bit_cnt_reg   <= bit_cnt_reg + BIT_W'(1);
                            tx_serial_reg <= sh_out;
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (bit_cnt_reg == STOP_LAST) begin
                            state_reg    <= ST_IDLE;
                            bit_cnt_reg  <= '0;
                            tx_ready_reg <= 1'b1;
                            tx_done_reg  <= 1'b1;
                        end else begin
                            bit_cnt_reg  <= bit_cnt_reg + BIT_W'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx.tx_ready  = tx_ready_reg;
    assign tx.tx_serial = tx_serial_reg;
    assign tx.tx_done   = tx_done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-scenario tasks compare captured line,
// ready and done waveforms against a frame-level reference model.
module tb_uart_tx;

    localparam int C = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_if #(.DATA_WIDTH(8)) ifa ();
    uart_tx_if #(.DATA_WIDTH(8)) ifb ();

    uart_tx #(.CLKS_PER_BIT(C), .DATA_WIDTH(8), .STOP_BITS(1)) dut_a (
        .clk (clk), .rst (rst), .tx (ifa.slave)
    );
    uart_tx #(.CLKS_PER_BIT(C), .DATA_WIDTH(8), .STOP_BITS(2)) dut_b (
        .clk (clk), .rst (rst), .tx (ifb.slave)
    );

    int errors = 0;
    int checks = 0;

    logic ser_q[$], rdy_q[$], done_q[$];
    logic exp_ser[$], exp_rdy[$], exp_done[$];

    // Reference: a frame is start(0), 8 data bits LSB first, one stop(1),
    // each held C clocks; with valid held, one idle ready clock between frames.
    function automatic logic frame_bit(input logic [7:0] w, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return w[b-1];
        return 1'b1;
    endfunction

    task automatic build_exp(input logic [7:0] w0, input logic [7:0] w1,
                             input int nw, input int total);
        exp_ser.delete(); exp_rdy.delete(); exp_done.delete();
        for (int f = 0; f < nw; f++) begin
            for (int b = 0; b < 10; b++) begin
                for (int c = 0; c < C; c++) begin
                    exp_ser.push_back(frame_bit(f == 0 ? w0 : w1, b));
                    exp_rdy.push_back(1'b0);
                    exp_done.push_back(1'b0);
                end
            end
            exp_ser.push_back(1'b1); exp_rdy.push_back(1'b1); exp_done.push_back(1'b1);
        end
        while (exp_ser.size() < total) begin
            exp_ser.push_back(1'b1); exp_rdy.push_back(1'b1); exp_done.push_back(1'b0);
        end
    endtask

    task automatic capture(input int n);
        ser_q.delete(); rdy_q.delete(); done_q.delete();
        repeat (n) begin
            @(negedge clk);
            ser_q.push_back(ifa.tx_serial);
            rdy_q.push_back(ifa.tx_ready);
            done_q.push_back(ifa.tx_done);
        end
    endtask

    function automatic logic got_at(input int s, input int i);
        return (s == 0) ? ser_q[i] : (s == 1) ? rdy_q[i] : done_q[i];
    endfunction

    function automatic logic exp_at(input int s, input int i);
        return (s == 0) ? exp_ser[i] : (s == 1) ? exp_rdy[i] : exp_done[i];
    endfunction

    function automatic string sig_name(input int s);
        return (s == 0) ? "serial" : (s == 1) ? "ready" : "done";
    endfunction

    function automatic int first_diff(input int s);
        for (int i = 0; i < exp_ser.size(); i++)
            if (i >= ser_q.size() || got_at(s, i) !== exp_at(s, i)) return i;
        return -1;
    endfunction

    function automatic logic [9:0] period_bits();
        logic [9:0] v;
        for (int b = 0; b < 10; b++) v[b] = ser_q[b*C + C/2];
        return v;
    endfunction

    task automatic start_frame(input logic [7:0] w);
        @(posedge clk); #1;
        ifa.tx_data  = w;
        ifa.tx_valid = 1'b1;
        @(posedge clk); #1;
        ifa.tx_valid = 1'b0;
        ifa.tx_data  = 8'($urandom);
    endtask

    task automatic test_reset;
        int bad;
        repeat (2) @(negedge clk);
        checks++; if (ifa.tx_serial !== 1'b1) begin errors++; $display("FAIL reset_serial got=%b expected=1", ifa.tx_serial); end
        checks++; if (ifa.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b expected=1", ifa.tx_ready); end
        checks++; if (ifa.tx_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b expected=0", ifa.tx_done); end
        rst = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (ifa.tx_serial !== 1'b1 || ifa.tx_ready !== 1'b1 || ifa.tx_done !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL idle_100 bad_cycles got=%0d expected=0", bad); end
        $display("reset/idle: %0d idle cycles checked", 100);
    endtask

    task automatic test_send_a5;
        int idx, lows, pulses, pidx;
        logic [9:0] want = 10'b1101001010;
        start_frame(8'hA5);
        capture(48);
        build_exp(8'hA5, 8'h00, 1, 48);
        for (int s = 0; s < 3; s++) begin
            idx = first_diff(s);
            checks++; if (idx != -1) begin errors++; $display("FAIL a5_%s idx=%0d got=%b expected=%b", sig_name(s), idx, got_at(s, idx), exp_at(s, idx)); end
        end
        checks++; if (period_bits() !== want) begin errors++; $display("FAIL a5_bits got=%b expected=%b", period_bits(), want); end
        lows = 0; pulses = 0; pidx = -1;
        for (int i = 0; i < 48; i++) begin
            if (rdy_q[i] === 1'b0) lows++;
            if (done_q[i] === 1'b1) begin pulses++; pidx = i; end
        end
        checks++; if (lows !== 40) begin errors++; $display("FAIL a5_ready_low got=%0d expected=40", lows); end
        checks++; if (pulses !== 1 || pidx !== 40) begin errors++; $display("FAIL a5_done got=%0d pulses at %0d expected=1 at 40", pulses, pidx); end
        $display("send 0xA5: line bits %b", period_bits());
    endtask

    task automatic test_data_after_accept;
        int idx, pulses;
        logic [7:0] dbits;
        start_frame(8'h3C);
        ifa.tx_data = 8'hFF;
        fork
            capture(60);
            begin
                repeat (15) @(posedge clk);
                #1 ifa.tx_valid = 1'b1;
                @(posedge clk);
                #1 ifa.tx_valid = 1'b0;
            end
        join
        build_exp(8'h3C, 8'h00, 1, 60);
        for (int s = 0; s < 3; s++) begin
            idx = first_diff(s);
            checks++; if (idx != -1) begin errors++; $display("FAIL 3c_%s idx=%0d got=%b expected=%b", sig_name(s), idx, got_at(s, idx), exp_at(s, idx)); end
        end
        for (int j = 0; j < 8; j++) dbits[j] = ser_q[(1+j)*C + C/2];
        checks++; if (dbits !== 8'h3C) begin errors++; $display("FAIL 3c_data got=%h expected=3c", dbits); end
        pulses = 0;
        for (int i = 0; i < 60; i++) if (done_q[i] === 1'b1) pulses++;
        checks++; if (pulses !== 1) begin errors++; $display("FAIL 3c_done_count got=%0d expected=1", pulses); end
        $display("send 0x3C with late data change: data %h, %0d done pulse(s)", dbits, pulses);
    endtask

    task automatic test_back_to_back;
        int idx, run, p0, p1, np;
        @(posedge clk); #1;
        ifa.tx_data = 8'h00; ifa.tx_valid = 1'b1;
        @(posedge clk); #1;
        ifa.tx_data = 8'hFF;
        fork
            capture(90);
            begin
                repeat (41) @(posedge clk);
                #1 ifa.tx_valid = 1'b0;
            end
        join
        build_exp(8'h00, 8'hFF, 2, 90);
        for (int s = 0; s < 3; s++) begin
            idx = first_diff(s);
            checks++; if (idx != -1) begin errors++; $display("FAIL b2b_%s idx=%0d got=%b expected=%b", sig_name(s), idx, got_at(s, idx), exp_at(s, idx)); end
        end
        run = 0;
        for (int i = 9*C; i < 90 && ser_q[i] === 1'b1; i++) run++;
        checks++; if (run !== 5) begin errors++; $display("FAIL b2b_stop_len got=%0d expected=5", run); end
        np = 0; p0 = -1; p1 = -1;
        for (int i = 0; i < 90; i++) if (done_q[i] === 1'b1) begin
            if (np == 0) p0 = i; else p1 = i;
            np++;
        end
        checks++; if (np !== 2 || (p1 - p0) !== 41) begin errors++; $display("FAIL b2b_done got=%0d pulses spacing %0d expected=2 pulses spacing 41", np, p1 - p0); end
        $display("back-to-back 0x00,0xFF: stop run %0d, %0d done pulses", run, np);
    endtask

    task automatic test_reset_midframe;
        int idx;
        logic [9:0] want = 10'b1100000010;
        start_frame(8'h55);
        repeat (17) @(negedge clk);
        checks++; if (ifa.tx_ready !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b expected=0", ifa.tx_ready); end
        #1 rst = 1'b1;
        #1;
        checks++; if (ifa.tx_serial !== 1'b1) begin errors++; $display("FAIL mid_rst_serial got=%b expected=1", ifa.tx_serial); end
        checks++; if (ifa.tx_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got=%b expected=1", ifa.tx_ready); end
        checks++; if (ifa.tx_done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got=%b expected=0", ifa.tx_done); end
        @(negedge clk);
        rst = 1'b0;
        start_frame(8'h81);
        capture(45);
        build_exp(8'h81, 8'h00, 1, 45);
        for (int s = 0; s < 3; s++) begin
            idx = first_diff(s);
            checks++; if (idx != -1) begin errors++; $display("FAIL 81_%s idx=%0d got=%b expected=%b", sig_name(s), idx, got_at(s, idx), exp_at(s, idx)); end
        end
        checks++; if (period_bits() !== want) begin errors++; $display("FAIL 81_bits got=%b expected=%b", period_bits(), want); end
        $display("reset mid-frame then 0x81: line bits %b", period_bits());
    endtask

    task automatic test_random_frames;
        int idx;
        logic [7:0] w;
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            w = 8'($urandom);
            start_frame(w);
            capture(42);
            build_exp(w, 8'h00, 1, 42);
            for (int s = 0; s < 3; s++) begin
                idx = first_diff(s);
                checks++; if (idx != -1) begin errors++; $display("FAIL rand%0d_%s word=%h idx=%0d got=%b expected=%b", k, sig_name(s), w, idx, got_at(s, idx), exp_at(s, idx)); end
            end
            $display("random frame %0d: word %h", k, w);
        end
    endtask

    // Loopback receiver on the 2-stop-bit instance: hunts the start edge,
    // then samples each bit at its centre.
    task automatic test_loopback;
        int n, done_off, flen;
        logic [7:0] rx;
        logic frame_ok;
        for (int w = 0; w < 256; w++) begin
            @(posedge clk); #1;
            ifb.tx_data = w[7:0]; ifb.tx_valid = 1'b1;
            @(posedge clk); #1;
            ifb.tx_valid = 1'b0; ifb.tx_data = 8'($urandom);
            n = 0;
            do begin @(negedge clk); n++; end while (ifb.tx_serial === 1'b1 && n < 8);
            rx = '0; frame_ok = 1'b1; done_off = -1;
            for (int off = 1; off <= 60 && done_off < 0; off++) begin
                @(negedge clk);
                if (off == C/2 && ifb.tx_serial !== 1'b0) frame_ok = 1'b0;
                for (int j = 0; j < 8; j++) if (off == (1+j)*C + C/2) rx[j] = ifb.tx_serial;
                if ((off == 9*C + C/2 || off == 10*C + C/2) && ifb.tx_serial !== 1'b1) frame_ok = 1'b0;
                if (ifb.tx_done === 1'b1) done_off = off;
            end
            flen = (done_off < 0) ? -1 : (n - 1) + done_off;
            checks++; if (rx !== w[7:0]) begin errors++; $display("FAIL loop_word got=%h expected=%h", rx, w[7:0]); end
            checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL loop_framing word=%h got=bad start/stop expected=start 0 stops 1", w[7:0]); end
            checks++; if (flen !== 44) begin errors++; $display("FAIL loop_len word=%h got=%0d expected=44", w[7:0], flen); end
            $display("loopback word %h: received %h, frame %0d clks", w[7:0], rx, flen);
        end
    endtask

    initial begin
        ifa.tx_valid = 1'b0; ifa.tx_data = 8'h00;
        ifb.tx_valid = 1'b0; ifb.tx_data = 8'h00;
        #2 rst = 1'b1;
        test_reset();
        test_send_a5();
        test_data_after_accept();
        test_back_to_back();
        test_reset_midframe();
        test_random_frames();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=timeout expected=completion");
        $fatal(1, "watchdog");
    end

endmodule
